// File: rtl/sram_ctrl_gen.sv
// rtl/sram_ctrl_gen.sv - parametrised requester-to-16-bit SRAM controller with beat splitting
module sram_ctrl_gen #(
    parameter int          DATA_W    = 32,
    parameter int          SRAM_DW   = 16,
    parameter int          SRAM_AW   = 18,
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter int          WR_PULSE  = 1,
    parameter int          WR_TAIL   = 4,
    parameter int          RD_WAIT   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wrEn,
    input  logic                rdEn,
    input  logic [31:0]         address,
    input  logic [DATA_W-1:0]   writeData,
    output logic [DATA_W-1:0]   readData,
    output logic                ready,
    output logic                err,
    output logic                busy,
    inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
    output logic [SRAM_AW-1:0]  SRAM_ADDR,
    output logic                SRAM_WE_N,
    output logic                SRAM_UB_N,
    output logic                SRAM_LB_N,
    output logic                SRAM_CE_N,
    output logic                SRAM_OE_N
);

    localparam int BEATS = DATA_W / SRAM_DW;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BSH   = $clog2(DATA_W / 8);
    localparam logic [63:0]   WORDS      = 64'((64'd1 << SRAM_AW) / BEATS);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
    localparam logic [15:0]   PULSE_LAST = 16'(WR_PULSE - 1);
    localparam logic [15:0]   TAIL_LAST  = 16'((WR_TAIL > 0) ? WR_TAIL - 1 : 0);
    localparam logic [15:0]   RD_LAST    = 16'(RD_WAIT);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WTAIL, S_READ, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    rbuf_q, rbuf_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [SRAM_AW-1:0]   addr_q, addr_d;
    logic                 we_n_q, we_n_d;
    logic [31:0]          offset, word_full, bofs;

    assign bofs = 32'(beat_q) * SRAM_DW;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            we_n_q  <= we_n_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        cnt_d     = cnt_q;
        wdata_d   = wdata_q;
        rbuf_d    = rbuf_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        addr_d    = addr_q;
        offset    = address - BASE_ADDR;
        word_full = offset >> BSH;
        case (state_q)
            S_IDLE: begin
                if (wrEn || rdEn) begin
                    beat_d = '0;
                    cnt_d  = '0;
                    err_d  = 1'b0;
                    if ((address < BASE_ADDR) || ({32'd0, word_full} >= WORDS)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        // consecutive SRAM words per access, so later beats just increment
                        addr_d  = word_full[SRAM_AW-1:0] * SRAM_AW'(BEATS);
                        state_d = wrEn ? S_WRITE : S_READ;
                        if (wrEn) wdata_d = writeData;
                    end
                end
            end
            S_WRITE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d = '0;
                    if (beat_q == LAST_BEAT) begin
                        state_d = (WR_TAIL == 0) ? S_DONE : S_WTAIL;
                    end else begin
                        beat_d = beat_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WTAIL: begin
                if (cnt_q == TAIL_LAST) state_d = S_DONE;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            S_READ: begin
                if (cnt_q == RD_LAST) begin
                    cnt_d = '0;
                    rbuf_d[bofs +: SRAM_DW] = SRAM_DQ;
                    if (beat_q == LAST_BEAT) begin
                        rdata_d = rbuf_d;
                        state_d = S_DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        we_n_d = (state_d != S_WRITE);
    end

    assign readData  = rdata_q;
    assign ready     = (state_q == S_DONE);
    assign err       = ready & err_q;
    assign busy      = (state_q != S_IDLE);
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = (state_q == S_WRITE) || (state_q == S_WTAIL);
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_DQ   = (state_q == S_WRITE) ? wdata_q[bofs +: SRAM_DW] : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_sram_ctrl_gen.sv
// tb/tb_sram_ctrl_gen.sv - directed bench for sram_ctrl_gen, default and 64-bit/RD_WAIT=0 builds
module tb_sram_ctrl_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        wr_a, rd_a, wr_b, rd_b;
    logic [31:0] addr_a, addr_b, wd_a, rdd_a;
    logic [63:0] wd_b, rdd_b;
    logic        rdy_a, err_a, busy_a, we_a, ub_a, lb_a, ce_a, oe_a;
    logic        rdy_b, err_b, busy_b, we_b, ub_b, lb_b, ce_b, oe_b;
    logic [17:0] sa_a, sa_b;
    wire  [15:0] dq_a, dq_b;

    sram_ctrl_gen dut_a (
        .clk(clk), .rst(rst), .wrEn(wr_a), .rdEn(rd_a), .address(addr_a),
        .writeData(wd_a), .readData(rdd_a), .ready(rdy_a), .err(err_a), .busy(busy_a),
        .SRAM_DQ(dq_a), .SRAM_ADDR(sa_a), .SRAM_WE_N(we_a), .SRAM_UB_N(ub_a),
        .SRAM_LB_N(lb_a), .SRAM_CE_N(ce_a), .SRAM_OE_N(oe_a));

    sram_ctrl_gen #(.DATA_W(64), .RD_WAIT(0)) dut_b (
        .clk(clk), .rst(rst), .wrEn(wr_b), .rdEn(rd_b), .address(addr_b),
        .writeData(wd_b), .readData(rdd_b), .ready(rdy_b), .err(err_b), .busy(busy_b),
        .SRAM_DQ(dq_b), .SRAM_ADDR(sa_b), .SRAM_WE_N(we_b), .SRAM_UB_N(ub_b),
        .SRAM_LB_N(lb_b), .SRAM_CE_N(ce_b), .SRAM_OE_N(oe_b));

    // asynchronous-read SRAM models, write on clock while WE_N low
    logic [15:0] mem_a [0:4095];
    logic [15:0] mem_b [0:4095];
    assign dq_a = (!oe_a && we_a) ? mem_a[sa_a[11:0]] : 16'hzzzz;
    assign dq_b = (!oe_b && we_b) ? mem_b[sa_b[11:0]] : 16'hzzzz;
    always @(posedge clk) if (!we_a) mem_a[sa_a[11:0]] <= dq_a;
    always @(posedge clk) if (!we_b) mem_b[sa_b[11:0]] <= dq_b;

    int          sel = 0;
    wire         m_busy  = (sel != 0) ? busy_b : busy_a;
    wire         m_ready = (sel != 0) ? rdy_b  : rdy_a;
    wire         m_err   = (sel != 0) ? err_b  : err_a;
    wire         m_we    = (sel != 0) ? we_b   : we_a;
    wire         m_oe    = (sel != 0) ? oe_b   : oe_a;
    wire [2:0]   m_tie   = (sel != 0) ? {ce_b, ub_b, lb_b} : {ce_a, ub_a, lb_a};
    wire [17:0]  m_addr  = (sel != 0) ? sa_b   : sa_a;
    wire [15:0]  m_dq    = (sel != 0) ? dq_b   : dq_a;
    wire [63:0]  m_rdata = (sel != 0) ? rdd_b  : {32'd0, rdd_a};

    logic        chk_on = 1'b0;
    logic        e_busy, e_ready, e_err, e_we, e_oe, e_addr_v, e_dq_v;
    logic [17:0] e_addr;
    logic [15:0] e_dq;
    logic [63:0] rdata_m [2];
    int          k_now = 0;
    int          ready_at = -1;
    int          checks = 0;
    int          errors = 0;
    logic        lit_pend = 1'b0;
    string       lit_nm;
    logic [63:0] lit_act, lit_exp;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy",     64'(m_busy),  64'(e_busy));
            chk("ready",    64'(m_ready), 64'(e_ready));
            chk("we_n",     64'(m_we),    64'(e_we));
            chk("oe_n",     64'(m_oe),    64'(e_oe));
            chk("ties",     64'(m_tie),   64'd0);
            chk("readData", m_rdata,      rdata_m[sel]);
            if (e_ready)  chk("err",  64'(m_err),  64'(e_err));
            if (e_addr_v) chk("addr", 64'(m_addr), 64'(e_addr));
            if (e_dq_v)   chk("dq",   64'(m_dq),   64'(e_dq));
            if (m_ready)  ready_at = k_now;
        end
        if (lit_pend) chk(lit_nm, lit_act, lit_exp);
    end

    task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
        lit_nm = nm; lit_act = act; lit_exp = exp; lit_pend = 1'b1;
        @(negedge clk); #1 lit_pend = 1'b0;
    endtask

    task automatic set_exp(input logic b, input logic rdy, input logic er, input logic we,
                           input logic oe, input logic av, input logic [17:0] ad,
                           input logic dv, input logic [15:0] d);
        e_busy = b; e_ready = rdy; e_err = er; e_we = we; e_oe = oe;
        e_addr_v = av; e_addr = ad; e_dq_v = dv; e_dq = d;
    endtask

    task automatic drive(input int s, input logic w, input logic r,
                         input logic [31:0] ad, input logic [63:0] wd);
        if (s == 0) begin wr_a = w; rd_a = r; addr_a = ad; wd_a = wd[31:0]; end
        else        begin wr_b = w; rd_b = r; addr_b = ad; wd_b = wd;       end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            k_now = 0;
            wr_a = 1'b0; rd_a = 1'b0; wr_b = 1'b0; rd_b = 1'b0;
            set_exp(0, 0, 0, 1, 0, 0, '0, 0, '0);
        end
    endtask

    // one access: cycle 0 = request sampled, expectations derived from the latency rules
    task automatic access(input int s, input logic w, input logic r, input logic [31:0] ad,
                          input logic [63:0] wd, input logic [63:0] rexp,
                          input bit keep, input int pulse_k);
        int nbeat, pw, tail, rw, nbytes, len, bt;
        logic [31:0] word;
        bit bad;
        nbeat = (s != 0) ? 4 : 2; pw = 1; tail = 4;
        rw = (s != 0) ? 0 : 1; nbytes = (s != 0) ? 8 : 4;
        @(posedge clk); #1;
        sel = s; k_now = 0;
        drive(s, w, r, ad, wd);
        set_exp(0, 0, 0, 1, 0, 0, '0, 0, '0);
        bad  = (ad < 32'd1024);
        word = (ad - 32'd1024) / nbytes;
        if (!bad && word >= 32'(262144 / nbeat)) bad = 1'b1;
        len = bad ? 1 : (w ? 1 + nbeat * pw + tail : 1 + nbeat * (rw + 1));
        for (int k = 1; k <= len; k++) begin
            @(posedge clk); #1;
            k_now = k;
            if (k == pulse_k)  drive(s, 1, 1, 32'd1000, 64'h0);
            else if (!keep)    drive(s, 0, 0, ad, wd);
            set_exp(1, 0, 0, 1, 0, 0, '0, 0, '0);
            if (k == len) begin
                e_ready = 1'b1; e_err = bad;
                if (!bad && !w) rdata_m[s] = rexp;
            end else if (w) begin
                e_oe = 1'b1;
                if (k <= nbeat * pw) begin
                    bt = (k - 1) / pw;
                    e_we = 1'b0; e_addr_v = 1'b1; e_addr = 18'(word * nbeat + bt);
                    e_dq_v = 1'b1; e_dq = wd[bt*16 +: 16];
                end
            end else begin
                bt = (k - 1) / (rw + 1);
                e_addr_v = 1'b1; e_addr = 18'(word * nbeat + bt);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1;
        rdata_m[0] = '0; rdata_m[1] = '0;
        wr_a = 0; rd_a = 0; addr_a = '0; wd_a = '0;
        wr_b = 0; rd_b = 0; addr_b = '0; wd_b = '0;
        set_exp(0, 0, 0, 1, 0, 0, '0, 0, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; chk_on = 1'b1;
        lit("rst_addr_a", 64'(sa_a), 64'd0);
        lit("rst_addr_b", 64'(sa_b), 64'd0);
        idle(2);

        access(0, 1, 0, 32'd1032, 64'hDEADBEEF, '0, 0, 0);
        idle(1);
        lit("wr_latency", 64'(ready_at), 64'd7);
        lit("mem4", 64'(mem_a[4]), 64'h0000_0000_0000_BEEF);
        lit("mem5", 64'(mem_a[5]), 64'h0000_0000_0000_DEAD);

        access(0, 0, 1, 32'd1032, '0, 64'hDEADBEEF, 0, 0);
        idle(1);
        lit("rd_latency", 64'(ready_at), 64'd5);
        lit("rd_data", 64'(rdd_a), 64'h0000_0000_DEAD_BEEF);

        access(0, 1, 1, 32'd1024, 64'hCAFEF00D, '0, 0, 0);
        idle(1);
        lit("prio_mem0", 64'(mem_a[0]), 64'h0000_0000_0000_F00D);
        lit("prio_mem1", 64'(mem_a[1]), 64'h0000_0000_0000_CAFE);

        access(0, 1, 0, 32'd1000, 64'h11111111, '0, 0, 0);
        idle(1);
        lit("err_latency", 64'(ready_at), 64'd1);
        lit("err_rd_hold", 64'(rdd_a), 64'h0000_0000_DEAD_BEEF);

        access(0, 1, 0, 32'd525308, 64'h5A5AA5A5, '0, 0, 0);
        access(0, 1, 0, 32'd525312, 64'h12121212, '0, 0, 0);
        idle(1);
        lit("top_mem_lo", 64'(mem_a[4094]), 64'h0000_0000_0000_A5A5);

        access(0, 0, 1, 32'd1024, '0, 64'hCAFEF00D, 1, 0);
        access(0, 0, 1, 32'd1024, '0, 64'hCAFEF00D, 0, 0);
        idle(2);

        access(0, 1, 0, 32'd1036, 64'h76543210, '0, 0, 3);
        idle(6);

        @(posedge clk); #1;
        sel = 0; k_now = 0;
        drive(0, 1, 0, 32'd1032, 64'h11112222);
        set_exp(0, 0, 0, 1, 0, 0, '0, 0, '0);
        @(posedge clk); #1;
        drive(0, 0, 0, 32'd1032, 64'h11112222);
        set_exp(1, 0, 0, 0, 1, 1, 18'd4, 1, 16'h2222);
        @(posedge clk); #1;
        rst = 1'b1;
        set_exp(1, 0, 0, 0, 1, 1, 18'd5, 1, 16'h1111);
        @(posedge clk); #1;
        rst = 1'b0;
        rdata_m[0] = '0; rdata_m[1] = '0;
        set_exp(0, 0, 0, 1, 0, 0, '0, 0, '0);
        idle(2);
        access(0, 0, 1, 32'd1024, '0, 64'hCAFEF00D, 0, 0);
        access(0, 0, 1, 32'd1036, '0, 64'h76543210, 0, 0);
        idle(1);

        access(1, 1, 0, 32'd1040, 64'h0123456789ABCDEF, '0, 0, 0);
        idle(1);
        lit("b_mem8",  64'(mem_b[8]),  64'h0000_0000_0000_CDEF);
        lit("b_mem11", 64'(mem_b[11]), 64'h0000_0000_0000_0123);
        access(1, 0, 1, 32'd1040, '0, 64'h0123456789ABCDEF, 0, 0);
        idle(1);
        lit("b_rd_latency", 64'(ready_at), 64'd5);
        lit("b_rd_data", rdd_b, 64'h0123456789ABCDEF);
        idle(2);

        chk_on = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_ctrl_gen.md
Name: sram_ctrl_gen

Overview:
- Parametrised successor of the fixed 32-bit/16-bit SRAM controller. Sits between the MEM stage and the external 16-bit SRAM.
- Splits a DATA_W-bit access into DATA_W/SRAM_DW SRAM beats.
- Write pulse length, write tail, read wait states and base address are all configurable.
- Adds out-of-range error reporting, a busy flag, OE_N gating during writes, and a registered read result that holds between reads.

Parameters:
DATA_W, 32, requester data width; DATA_W/SRAM_DW (BEATS) must be a power of 2, ≥1
SRAM_DW, 16, SRAM data bus width
SRAM_AW, 18, SRAM address width
BASE_ADDR, 1024, byte address mapped to SRAM word 0
WR_PULSE, 1, cycles WE_N is held low per write beat (≥1)
WR_TAIL, 4, idle cycles after last write beat before ready (≥0)
RD_WAIT, 1, extra cycles the address is held per read beat before capture (≥0)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wrEn  in  1  write request
rdEn  in  1  read request
address  in  32  byte address
writeData  in  DATA_W  write data
readData  out  DATA_W  last successfully read word (registered)
ready  out  1  one-cycle completion pulse
err  out  1  valid with ready; 1 = address out of range, no SRAM access
busy  out  1  state != IDLE
SRAM_DQ  inout  SRAM_DW  SRAM data
SRAM_ADDR  out  SRAM_AW  SRAM address (registered)
SRAM_WE_N  out  1  write enable, active low (registered)
SRAM_UB_N, SRAM_LB_N, SRAM_CE_N  out  1 each  tied 0
SRAM_OE_N  out  1  1 in WRITE/WTAIL, else 0

Behaviour:
- Reset (sync, high): state IDLE, ready=0, err=0, busy=0, readData=0, SRAM_ADDR=0, SRAM_WE_N=1, SRAM_DQ=Z, beat and cycle counters cleared.
- Reset mid-access aborts at that edge: WE_N=1 and DQ released the next cycle; no ready pulse.
- States: IDLE, WRITE, WTAIL, READ, DONE.
- IDLE: requests are sampled only here.
  - wrEn has priority over rdEn.
  - address, writeData and op are latched.
  - word = (address-BASE_ADDR) >> log2(DATA_W/8).
  - If address<BASE_ADDR or word ≥ 2^SRAM_AW/BEATS, go to DONE with err=1; no SRAM strobes, readData unchanged.
  - Otherwise go to WRITE or READ with beat=0.
- SRAM address for a beat = word*BEATS + beat. Beat 0 carries the least significant slice.
- WRITE: SRAM_ADDR and DQ = writeData[beat slice] are driven, WE_N=0, for WR_PULSE cycles per beat. After the last beat, go to WTAIL, or to DONE if WR_TAIL=0.
- WTAIL: WE_N=1, DQ=Z, OE_N=1 for WR_TAIL cycles, then DONE.
- READ: SRAM_ADDR is held RD_WAIT+1 cycles per beat. On the final cycle of each beat, SRAM_DQ is captured into the read buffer slice. After the last beat, go to DONE.
- DONE: ready=1 for exactly one cycle, err as determined. For a successful read, readData <= read buffer (visible with ready). Then IDLE.
- Enables are ignored in every state except IDLE. Enables still high in the IDLE after DONE start a new access; the requester must drop them on ready.
- Latency, request sampled in IDLE at cycle 0, ready high in cycle:
  - write: 1 + BEATS*WR_PULSE + WR_TAIL
  - read: 1 + BEATS*(RD_WAIT+1)
  - error: 1
- Defaults give write=7, read=5.
- SRAM_DQ is driven only in WRITE; Z otherwise. address arithmetic is 32-bit unsigned.

Test Plan:
- Write 0xDEADBEEF @1032 (defaults) -> SRAM_ADDR 4 then 5, DQ 0xBEEF then 0xDEAD with WE_N=0 in cycles 1-2; ready in cycle 7; busy=1 in cycles 1-7; err=0.
- Read @1032 from the SRAM model -> ADDR 4 in cycles 1-2, 5 in cycles 3-4; readData=0xDEADBEEF and ready in cycle 5; WE_N=1 throughout.
- wrEn=rdEn=1 @1024 -> write is performed (WE_N low at ADDR 0); address 1000 -> ready+err in cycle 1, no WE_N low, readData unchanged.
- DATA_W=64, RD_WAIT=0: write 0x0123456789ABCDEF @1040 -> ADDR 8..11 with DQ CDEF, 89AB, 4567, 0123; read back -> 0x0123456789ABCDEF, ready in cycle 5.
- rst in cycle 2 of a write -> next cycle: WE_N=1, DQ=Z, state IDLE, no ready; a subsequent read is correct.
- Back-to-back: enables held through ready -> second access starts at the IDLE following DONE; enables pulsed while busy -> ignored.
